time_machine_sequencer: RTL and testbench

- Top-level mission controller for the time machine. It sequences the ship through rest, load, ready, charge, jump, arrive and unload.
- Performs the ship-loaded check on live crew, passenger and cargo counts, times the flux-capacitor charge, and steps the era register toward the target era.
- Sits above the load-check and comparator logic; its state code is the machine's global state bus.

---
 rtl/time_machine_sequencer.sv | 141 ++++++++++++++
 tb/tb_time_machine_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_machine_sequencer.sv
// Mission controller for the time machine: sequences load, charge, jump and unload,
// and owns the era register and the shared state timer.
module time_machine_sequencer #(
  parameter int unsigned CREW_REQ       = 4,
  parameter int unsigned MAX_PASSENGERS = 15,
  parameter int unsigned MAX_CARGO      = 15,
  parameter int unsigned LOAD_TIMEOUT   = 200,
  parameter int unsigned CHARGE_CYCLES  = 16,
  parameter int unsigned TIMER_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               launch,
  input  logic               abort,
  input  logic               fault_clr,
  input  logic [3:0]         crew_count,
  input  logic [3:0]         passenger_count,
  input  logic [3:0]         cargo_count,
  input  logic [3:0]         target_era,
  output logic [2:0]         state,
  output logic               busy,
  output logic               door_open,
  output logic               charging,
  output logic               jumping,
  output logic               fault,
  output logic [3:0]         current_era,
  output logic [TIMER_W-1:0] timer
);

  typedef enum logic [2:0] {
    S_REST   = 3'b000,
    S_LOAD   = 3'b001,
    S_READY  = 3'b010,
    S_CHARGE = 3'b011,
    S_JUMP   = 3'b100,
    S_ARRIVE = 3'b101,
    S_UNLOAD = 3'b110,
    S_FAULT  = 3'b111
  } state_t;

  state_t             st;
  logic [TIMER_W-1:0] tmr;
  logic [3:0]         era;
  logic [3:0]         tgt;
  logic               loaded;

  // Compared at 32 bits so a limit at the top of the 4-bit range stays a plain compare
  assign loaded = (32'(crew_count) == CREW_REQ) &&
                  (32'(passenger_count) <= MAX_PASSENGERS) &&
                  (32'(cargo_count) <= MAX_CARGO);

  // Every transition also clears the timer; otherwise it counts up and saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= S_REST;
      tmr <= '0;
      era <= '0;
      tgt <= '0;
    end else begin
      if (!(&tmr)) tmr <= tmr + TIMER_W'(1);
      case (st)
        S_REST: begin
          if (start) begin
            st  <= S_LOAD;
            tmr <= '0;
          end
        end
        S_LOAD: begin
          if (abort) begin
            st  <= S_REST;
            tmr <= '0;
          end else if (loaded) begin
            st  <= S_READY;
            tmr <= '0;
          end else if (tmr == TIMER_W'(LOAD_TIMEOUT - 1)) begin
            st  <= S_FAULT;
            tmr <= '0;
          end
        end
        S_READY: begin
          if (abort) begin
            st  <= S_REST;
            tmr <= '0;
          end else if (!loaded) begin
            st  <= S_LOAD;
            tmr <= '0;
          end else if (launch) begin
            st  <= S_CHARGE;
            tmr <= '0;
            tgt <= target_era;
          end
        end
        S_CHARGE: begin
          if (abort) begin
            st  <= S_REST;
            tmr <= '0;
          end else if (tmr == TIMER_W'(CHARGE_CYCLES - 1)) begin
            st  <= S_JUMP;
            tmr <= '0;
          end
        end
        // Era steps by one per cycle (mod 16) until it reaches the latched target
        S_JUMP: begin
          if (era == tgt) begin
            st  <= S_ARRIVE;
            tmr <= '0;
          end else begin
            era <= era + 4'd1;
          end
        end
        S_ARRIVE: begin
          st  <= S_UNLOAD;
          tmr <= '0;
        end
        S_UNLOAD: begin
          if (passenger_count == 4'd0 && cargo_count == 4'd0) begin
            st  <= S_REST;
            tmr <= '0;
          end
        end
        S_FAULT: begin
          if (fault_clr) begin
            st  <= S_REST;
            tmr <= '0;
          end
        end
      endcase
    end
  end

  assign state       = st;
  assign busy        = (st != S_REST);
  assign door_open   = (st == S_LOAD) || (st == S_UNLOAD);
  assign charging    = (st == S_CHARGE);
  assign jumping     = (st == S_JUMP);
  assign fault       = (st == S_FAULT);
  assign current_era = era;
  assign timer       = tmr;

endmodule

// File: tb/tb_time_machine_sequencer.sv
// Directed bench for time_machine_sequencer: expected state/flag/era words are queued
// as stimulus is applied and popped one per clock as the DUT advances.
module tb_time_machine_sequencer;

  localparam int unsigned TIMER_W = 8;

  localparam logic [2:0] REST   = 3'b000;
  localparam logic [2:0] LOAD   = 3'b001;
  localparam logic [2:0] READY  = 3'b010;
  localparam logic [2:0] CHARGE = 3'b011;
  localparam logic [2:0] JUMP   = 3'b100;
  localparam logic [2:0] ARRIVE = 3'b101;
  localparam logic [2:0] UNLOAD = 3'b110;
  localparam logic [2:0] FAULT  = 3'b111;

  logic               clk = 1'b0;
  logic               rst;
  logic               start, launch, abort, fault_clr;
  logic [3:0]         crew_count, passenger_count, cargo_count, target_era;
  logic [2:0]         state;
  logic               busy, door_open, charging, jumping, fault;
  logic [3:0]         current_era;
  logic [TIMER_W-1:0] timer;

  typedef struct {
    string      tag;
    logic [11:0] v;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] era_m  = 4'd0;

  time_machine_sequencer #(
    .CREW_REQ(4), .MAX_PASSENGERS(15), .MAX_CARGO(15),
    .LOAD_TIMEOUT(200), .CHARGE_CYCLES(16), .TIMER_W(TIMER_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .launch(launch), .abort(abort),
    .fault_clr(fault_clr), .crew_count(crew_count), .passenger_count(passenger_count),
    .cargo_count(cargo_count), .target_era(target_era), .state(state), .busy(busy),
    .door_open(door_open), .charging(charging), .jumping(jumping), .fault(fault),
    .current_era(current_era), .timer(timer)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference decode: state, busy, door_open, charging, jumping, fault, era
  function automatic logic [11:0] mk(input logic [2:0] s, input logic [3:0] e);
    return {s, s != REST, (s == LOAD) || (s == UNLOAD), s == CHARGE, s == JUMP, s == FAULT, e};
  endfunction

  function automatic logic [11:0] obs();
    return {state, busy, door_open, charging, jumping, fault, current_era};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [2:0] s, input logic [3:0] e);
    exp_t x;
    x.tag = tag;
    x.v   = mk(s, e);
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    logic [11:0] o;
    o = obs();
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow observed %h expected <none>", o);
    end else begin
      x = sb.pop_front();
      assert (o === x.v) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", x.tag, o, x.v);
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic step(input string tag, input logic [2:0] s);
    push(tag, s, era_m);
    tick();
    pop_check();
  endtask

  task automatic to_ready();
    start = 1'b1;
    push("enter_load", LOAD, era_m);
    tick();
    start = 1'b0;
    pop_check();
    step("enter_ready", READY);
  endtask

  // Full mission from READY through UNLOAD and back to REST
  task automatic mission(input logic [3:0] tgt, input bit abort_jump);
    logic [3:0] e;
    int         n;
    to_ready();
    launch     = 1'b1;
    target_era = tgt;
    for (int i = 0; i < 16; i++) push("charge", CHARGE, era_m);
    e = era_m;
    for (int i = 0; i < 16; i++) begin
      push("jump", JUMP, e);
      if (e == tgt) break;
      e = e + 4'd1;
    end
    push("arrive", ARRIVE, tgt);
    push("unload", UNLOAD, tgt);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0) begin
        launch     = 1'b0;
        target_era = tgt + 4'd7;
        check_val("charge_timer_start", 32'(timer), 32'd0);
      end
      if (i == 15) check_val("charge_timer_end", 32'(timer), 32'd15);
      pop_check();
      if (abort_jump && i == 16) abort = 1'b1;
    end
    abort           = 1'b0;
    passenger_count = 4'd0;
    cargo_count     = 4'd0;
    era_m           = tgt;
    step("unload_done", REST);
    passenger_count = 4'd2;
    cargo_count     = 4'd1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; launch = 1'b0; abort = 1'b0; fault_clr = 1'b0;
    crew_count = 4'd4; passenger_count = 4'd10; cargo_count = 4'd3; target_era = 4'd0;
    tick();
    tick();
    push("reset_state", REST, 4'd0);
    pop_check();
    check_val("reset_timer", 32'(timer), 32'd0);
    rst = 1'b0;
    step("idle_rest", REST);

    // Nominal mission 0 -> 5 with passengers and cargo aboard
    mission(4'd5, 1'b0);
    check_val("nominal_era", 32'(current_era), 32'd5);

    // Load timeout with one crew member short
    crew_count = 4'd3;
    start = 1'b1;
    push("timeout_load", LOAD, era_m);
    tick();
    start = 1'b0;
    pop_check();
    for (int i = 1; i < 200; i++) step("timeout_wait", LOAD);
    check_val("timeout_timer", 32'(timer), 32'd199);
    step("timeout_fault", FAULT);
    start = 1'b1;
    step("fault_ignores_start", FAULT);
    start = 1'b0;
    fault_clr = 1'b1;
    step("fault_clear", REST);
    fault_clr = 1'b0;

    // Boundary compares
    crew_count = 4'd4; passenger_count = 4'd15; cargo_count = 4'd15;
    to_ready();
    crew_count = 4'd3;
    step("crew_left", LOAD);
    crew_count = 4'd5;
    step("crew_over_a", LOAD);
    step("crew_over_b", LOAD);
    crew_count = 4'd4;
    step("crew_back", READY);

    // Abort beats launch in READY
    abort = 1'b1; launch = 1'b1;
    step("abort_beats_launch", REST);
    abort = 1'b0; launch = 1'b0;
    step("no_charge_after_abort", REST);

    // Abort in CHARGE at timer 7
    passenger_count = 4'd2; cargo_count = 4'd1;
    to_ready();
    launch = 1'b1; target_era = 4'd9;
    step("abort_charge_enter", CHARGE);
    launch = 1'b0;
    for (int i = 0; i < 7; i++) step("abort_charge_run", CHARGE);
    check_val("abort_charge_timer", 32'(timer), 32'd7);
    abort = 1'b1;
    step("abort_charge", REST);
    abort = 1'b0;
    check_val("abort_charge_era", 32'(current_era), 32'd5);

    // Long jump to 14, wrapping jump to 1 with abort ignored, then zero-length jump
    mission(4'd14, 1'b0);
    mission(4'd1, 1'b1);
    mission(4'd1, 1'b0);

    // Asynchronous reset in the middle of a jump
    to_ready();
    launch = 1'b1; target_era = 4'd10;
    step("rj_charge", CHARGE);
    launch = 1'b0;
    for (int i = 1; i < 16; i++) step("rj_charge_run", CHARGE);
    step("rj_jump0", JUMP);
    push("rj_jump1", JUMP, 4'd2);
    tick();
    pop_check();
    #2 rst = 1'b1;
    #1;
    push("rj_async_reset", REST, 4'd0);
    pop_check();
    check_val("rj_async_timer", 32'(timer), 32'd0);
    era_m = 4'd0;
    tick();
    rst = 1'b0;
    step("rj_after_release", REST);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
